// File: rtl/nzcv_cond_unit.sv
// NZCV flag register with writer scoreboard and condition evaluation.
// Forwards same-cycle flag writes into a 1-cycle registered pass/fail.
module nzcv_cond_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic       flag_wr_valid,
  input  logic [3:0] flag_wr_data,
  input  logic [3:0] flag_wr_mask,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       exec_valid,
  output logic       exec_pass,
  output logic [3:0] nzcv,
  output logic [1:0] pending,
  output logic       ovf_err
);

  logic [3:0] feff;
  logic       inc;
  logic       dec;
  logic       accept;
  logic       pass;

  function automatic logic eval(
    input logic [3:0] code,
    input logic [3:0] f
  );
    logic n, z, c, v;
    {n, z, c, v} = f;
    unique case (code)
      4'h0:    eval = z;
      4'h1:    eval = !z;
      4'h2:    eval = c;
      4'h3:    eval = !c;
      4'h4:    eval = n;
      4'h5:    eval = !n;
      4'h6:    eval = v;
      4'h7:    eval = !v;
      4'h8:    eval = c && !z;
      4'h9:    eval = !c || z;
      4'hA:    eval = n == v;
      4'hB:    eval = n != v;
      4'hC:    eval = !z && (n == v);
      4'hD:    eval = z || (n != v);
      4'hE:    eval = 1'b1;
      default: eval = 1'b0;
    endcase
  endfunction

  assign feff = flag_wr_valid
              ? (nzcv & ~flag_wr_mask)
                | (flag_wr_data & flag_wr_mask)
              : nzcv;

  assign inc = issue_valid && !flag_wr_valid;
  assign dec = flag_wr_valid && !issue_valid;

  // In reset the scoreboard is treated as already empty
  assign cond_ready = !rst_n
                   || (pending == 2'd0)
                   || (pending == 2'd1 && dec);

  assign accept = cond_valid && cond_ready;
  assign pass   = eval(cond_code, feff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv       <= 4'b0000;
      pending    <= 2'd0;
      ovf_err    <= 1'b0;
      exec_valid <= 1'b0;
      exec_pass  <= 1'b0;
    end else begin
      nzcv       <= feff;
      exec_valid <= accept;
      if (accept)
        exec_pass <= pass;
      if (inc) begin
        if (pending == 2'd3)
          ovf_err <= 1'b1;
        else
          pending <= pending + 2'd1;
      end else if (dec && pending != 2'd0) begin
        pending <= pending - 2'd1;
      end
    end
  end

endmodule

// File: doc/nzcv_cond_unit.md
NZCV_COND_UNIT -- requirements
Module: nzcv_cond_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 The ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  a flag-setting instruction entered execute.
- flag_wr_valid  in  1  ALU flag writeback this cycle.
- flag_wr_data  in  4  {N,Z,C,V} from the ALU.
- flag_wr_mask  in  4  per-bit write enable, bit3=N … bit0=V.
- cond_valid  in  1  condition-evaluation request.
- cond_code  in  4  condition field of the request.
- cond_ready  out  1  request may be accepted this cycle.
- exec_valid  out  1  registered result strobe.
- exec_pass  out  1  condition passed.
- nzcv  out  4  committed flag register {N,Z,C,V}.
- pending  out  2  count of outstanding flag writers.
- ovf_err  out  1  sticky pending-counter overflow flag.

Function
REQ-003 nzcv SHALL update at the clock edge when flag_wr_valid=1: each bit i with flag_wr_mask[i]=1 takes flag_wr_data[i], and bits with mask 0 hold.
REQ-004 The pending counter SHALL follow these rules:
- +1 on issue_valid alone.
- -1 on flag_wr_valid alone.
- Unchanged when both are asserted in the same cycle.
REQ-005 The pending counter SHALL saturate at 3: an increment at 3 leaves it at 3 and sets ovf_err=1.
REQ-006 A write with pending=0 SHALL be legal (direct flag write) and SHALL leave pending at 0 without error.
REQ-007 The effective flags feff SHALL be nzcv with the masked flag_wr_data merged in whenever flag_wr_valid=1 in the same cycle, i.e. the write is forwarded.
REQ-008 cond_ready SHALL be combinational and equal to (pending==0) OR (pending==1 AND flag_wr_valid=1 AND issue_valid=0).
REQ-009 A request SHALL be accepted only when cond_valid=1 and cond_ready=1; with cond_ready=0 the requester holds cond_code, and no result is produced.
REQ-010 An accepted request SHALL produce exec_valid=1 for exactly one cycle on the following clock edge (1-cycle latency).
REQ-011 exec_pass SHALL be registered from cond_code and feff sampled at acceptance, per this table:
- 0 Z; 1 !Z; 2 C; 3 !C.
- 4 N; 5 !N; 6 V; 7 !V.
- 8 C&!Z; 9 !C|Z.
- A N==V; B N!=V.
- C !Z&(N==V); D Z|(N!=V).
- E 1; F 0.
REQ-012 exec_pass SHALL hold its last value while exec_valid=0.
REQ-013 Back-to-back accepted requests SHALL produce back-to-back exec_valid pulses with no bubble.
REQ-014 ovf_err SHALL remain 1 until reset once set.

Reset
REQ-015 When rst_n=0 at a clock edge, the outputs SHALL take these values:
- nzcv=4'b0000, pending=0, ovf_err=0.
- exec_valid=0, exec_pass=0.
REQ-016 When rst_n=0 at a clock edge, any request accepted in that same cycle SHALL be discarded.
REQ-017 During reset cycles, cond_ready SHALL reflect pending=0, and no exec_valid SHALL be produced until the cycle after rst_n returns high.
REQ-018 Reset asserted mid-operation with pending>0 SHALL drop all outstanding writers; later flag writes SHALL be treated per REQ-006.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Forwarding: pending=0, write data=4'b0100 mask=4'b1111, with cond_valid=1 and code 0 in the same cycle -> one cycle later exec_valid=1, exec_pass=1, nzcv=4'b0100.
- Stall and release: issue_valid pulse (pending=1), cond_valid=1 code 2 -> cond_ready=0; two cycles later write data=4'b0010 mask=4'b0010 -> cond_ready=1 that cycle, next cycle exec_pass=1, pending=0.
- Masked write: nzcv=4'b1001, write data=4'b0110 mask=4'b0011 -> nzcv=4'b1010; then code C (GT) -> exec_pass=0, because N!=V.
- Saturation: four issue_valid pulses with no write -> pending=3, ovf_err=1; one write -> pending=2, ovf_err still 1.
- Simultaneous events: pending=1, issue_valid and flag_wr_valid in the same cycle -> pending stays 1 and cond_ready=0; code E then code F once ready -> exec_pass 1 then 0 on consecutive cycles.
- Reset mid-operation: pending=2, nzcv=4'b1111, request accepted in the reset cycle -> next cycle all outputs zero and exec_valid=0.
